// File: rtl/pcpi_dispatch.sv
// Fans one picorv32 PCPI request out to two coprocessors, hands ownership to the
// first claimant and returns its result; claim and busy watchdogs prevent CPU hangs.
module pcpi_dispatch #(
    parameter int CLAIM_CYCLES = 4,
    parameter int MAX_BUSY     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_pcpi_valid,
    input  logic [31:0] m_pcpi_insn,
    input  logic [31:0] m_pcpi_rs1,
    input  logic [31:0] m_pcpi_rs2,
    input  logic [31:0] m_pcpi_rs3,
    output logic        m_pcpi_wr,
    output logic [31:0] m_pcpi_rd,
    output logic        m_pcpi_wait,
    output logic        m_pcpi_ready,
    output logic [1:0]  s_pcpi_valid,
    output logic [31:0] s_pcpi_insn,
    output logic [31:0] s_pcpi_rs1,
    output logic [31:0] s_pcpi_rs2,
    output logic [31:0] s_pcpi_rs3,
    input  logic [1:0]  s_pcpi_wr,
    input  logic [63:0] s_pcpi_rd,
    input  logic [1:0]  s_pcpi_wait,
    input  logic [1:0]  s_pcpi_ready,
    output logic        err_abort,
    output logic        err_conflict
);
    // state | meaning
    // IDLE  | no request held
    // ISSUE | request broadcast to both coprocessors, claim window running
    // BUSY  | owner holds wait, busy watchdog running
    // RESP  | m_pcpi_ready pulse with the owner's result
    // DRAIN | request finished or declined, wait for the CPU to drop valid
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, DRAIN} state_t;

    localparam int CNT_SPAN = (CLAIM_CYCLES > MAX_BUSY) ? CLAIM_CYCLES : MAX_BUSY;
    localparam int CW       = $clog2(CNT_SPAN) + 1;
    localparam logic [CW-1:0] CLAIM_LAST = CW'(CLAIM_CYCLES - 1);
    localparam logic [CW-1:0] BUSY_LAST  = CW'(MAX_BUSY - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          owner, owner_n;
    logic          wr_n, wait_n, ready_n, abort_n, conflict_n;
    logic [31:0]   rd_n, insn_n, rs1_n, rs2_n, rs3_n;
    logic [1:0]    valid_n, claim;
    logic [31:0]   rd0, rd1;

    assign claim = s_pcpi_wait | s_pcpi_ready;
    assign rd0   = s_pcpi_rd[31:0];
    assign rd1   = s_pcpi_rd[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= 1'b0;
            m_pcpi_wr    <= 1'b0;
            m_pcpi_rd    <= '0;
            m_pcpi_wait  <= 1'b0;
            m_pcpi_ready <= 1'b0;
            s_pcpi_valid <= 2'b00;
            s_pcpi_insn  <= '0;
            s_pcpi_rs1   <= '0;
            s_pcpi_rs2   <= '0;
            s_pcpi_rs3   <= '0;
            err_abort    <= 1'b0;
            err_conflict <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            owner        <= owner_n;
            m_pcpi_wr    <= wr_n;
            m_pcpi_rd    <= rd_n;
            m_pcpi_wait  <= wait_n;
            m_pcpi_ready <= ready_n;
            s_pcpi_valid <= valid_n;
            s_pcpi_insn  <= insn_n;
            s_pcpi_rs1   <= rs1_n;
            s_pcpi_rs2   <= rs2_n;
            s_pcpi_rs3   <= rs3_n;
            err_abort    <= abort_n;
            err_conflict <= conflict_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        owner_n    = owner;
        wr_n       = m_pcpi_wr;
        rd_n       = m_pcpi_rd;
        wait_n     = m_pcpi_wait;
        ready_n    = 1'b0;
        valid_n    = s_pcpi_valid;
        insn_n     = s_pcpi_insn;
        rs1_n      = s_pcpi_rs1;
        rs2_n      = s_pcpi_rs2;
        rs3_n      = s_pcpi_rs3;
        abort_n    = 1'b0;
        conflict_n = 1'b0;
        case (state)
            IDLE: begin
                if (m_pcpi_valid) begin
                    insn_n  = m_pcpi_insn;
                    rs1_n   = m_pcpi_rs1;
                    rs2_n   = m_pcpi_rs2;
                    rs3_n   = m_pcpi_rs3;
                    valid_n = 2'b11;
                    cnt_n   = '0;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // A ready answer beats a wait claim; within each kind coprocessor 0 wins.
                if (!m_pcpi_valid) begin
                    valid_n = 2'b00;
                    state_n = IDLE;
                end else if (|s_pcpi_ready) begin
                    owner_n    = ~s_pcpi_ready[0];
                    rd_n       = s_pcpi_ready[0] ? rd0 : rd1;
                    wr_n       = s_pcpi_ready[0] ? s_pcpi_wr[0] : s_pcpi_wr[1];
                    valid_n    = 2'b00;
                    ready_n    = 1'b1;
                    conflict_n = &claim;
                    state_n    = RESP;
                end else if (|s_pcpi_wait) begin
                    owner_n    = ~s_pcpi_wait[0];
                    valid_n    = s_pcpi_wait[0] ? 2'b01 : 2'b10;
                    wait_n     = 1'b1;
                    cnt_n      = '0;
                    conflict_n = &claim;
                    state_n    = BUSY;
                end else if (cnt == CLAIM_LAST) begin
                    valid_n = 2'b00;
                    state_n = DRAIN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            BUSY: begin
                if (!m_pcpi_valid) begin
                    valid_n = 2'b00;
                    wait_n  = 1'b0;
                    state_n = IDLE;
                end else if (s_pcpi_ready[owner]) begin
                    rd_n    = owner ? rd1 : rd0;
                    wr_n    = s_pcpi_wr[owner];
                    valid_n = 2'b00;
                    wait_n  = 1'b0;
                    ready_n = 1'b1;
                    state_n = RESP;
                end else if (cnt == BUSY_LAST) begin
                    valid_n = 2'b00;
                    wait_n  = 1'b0;
                    abort_n = 1'b1;
                    state_n = DRAIN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RESP: begin
                state_n = DRAIN;
            end
            DRAIN: begin
                if (!m_pcpi_valid) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed and randomized transactions against two dispatcher instances (default and short
// busy watchdog); expectations come from a transaction-level outcome model.
module tb_pcpi_dispatch;
    localparam int CLAIM = 4;
    localparam int MB_A  = 1024;
    localparam int MB_B  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        m_valid;
    logic [31:0] m_insn, m_rs1, m_rs2, m_rs3;
    logic [1:0]  s_wr, s_wait, s_ready;
    logic [63:0] s_rd;

    logic        a_wr, a_wait, a_ready, a_abort, a_conf;
    logic [31:0] a_rd, a_insn, a_rs1, a_rs2, a_rs3;
    logic [1:0]  a_sv;
    logic        b_wr, b_wait, b_ready, b_abort, b_conf;
    logic [31:0] b_rd, b_insn, b_rs1, b_rs2, b_rs3;
    logic [1:0]  b_sv;

    logic        o_wr, o_wait, o_ready, o_abort, o_conf;
    logic [31:0] o_rd, o_insn, o_rs1, o_rs2, o_rs3;
    logic [1:0]  o_sv;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcpi_dispatch #(.CLAIM_CYCLES(CLAIM), .MAX_BUSY(MB_A)) u_a (
        .clk(clk), .reset(reset),
        .m_pcpi_valid(m_valid), .m_pcpi_insn(m_insn),
        .m_pcpi_rs1(m_rs1), .m_pcpi_rs2(m_rs2), .m_pcpi_rs3(m_rs3),
        .m_pcpi_wr(a_wr), .m_pcpi_rd(a_rd), .m_pcpi_wait(a_wait), .m_pcpi_ready(a_ready),
        .s_pcpi_valid(a_sv), .s_pcpi_insn(a_insn),
        .s_pcpi_rs1(a_rs1), .s_pcpi_rs2(a_rs2), .s_pcpi_rs3(a_rs3),
        .s_pcpi_wr(s_wr), .s_pcpi_rd(s_rd), .s_pcpi_wait(s_wait), .s_pcpi_ready(s_ready),
        .err_abort(a_abort), .err_conflict(a_conf)
    );

    pcpi_dispatch #(.CLAIM_CYCLES(CLAIM), .MAX_BUSY(MB_B)) u_b (
        .clk(clk), .reset(reset),
        .m_pcpi_valid(m_valid), .m_pcpi_insn(m_insn),
        .m_pcpi_rs1(m_rs1), .m_pcpi_rs2(m_rs2), .m_pcpi_rs3(m_rs3),
        .m_pcpi_wr(b_wr), .m_pcpi_rd(b_rd), .m_pcpi_wait(b_wait), .m_pcpi_ready(b_ready),
        .s_pcpi_valid(b_sv), .s_pcpi_insn(b_insn),
        .s_pcpi_rs1(b_rs1), .s_pcpi_rs2(b_rs2), .s_pcpi_rs3(b_rs3),
        .s_pcpi_wr(s_wr), .s_pcpi_rd(s_rd), .s_pcpi_wait(s_wait), .s_pcpi_ready(s_ready),
        .err_abort(b_abort), .err_conflict(b_conf)
    );

    assign o_wr    = sel ? b_wr    : a_wr;
    assign o_rd    = sel ? b_rd    : a_rd;
    assign o_wait  = sel ? b_wait  : a_wait;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_sv    = sel ? b_sv    : a_sv;
    assign o_insn  = sel ? b_insn  : a_insn;
    assign o_rs1   = sel ? b_rs1   : a_rs1;
    assign o_rs2   = sel ? b_rs2   : a_rs2;
    assign o_rs3   = sel ? b_rs3   : a_rs3;
    assign o_abort = sel ? b_abort : a_abort;
    assign o_conf  = sel ? b_conf  : a_conf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {58'd0, o_wr, o_wait, o_ready, o_sv, o_abort, o_conf}, 64'd0);
        chk({tag, "_data"}, {32'd0, o_rd | o_insn | o_rs1 | o_rs2 | o_rs3}, 64'd0);
    endtask

    // Coprocessor profile kind: 0 silent, 1 ready at valid-cycle d, 2 wait from d for l
    // cycles then ready, 3 wait from d forever. rst_at >= 0 pulses reset in that cycle.
    task automatic run_txn(input int k0, d0, l0, k1, d1, l1,
                           input logic [31:0] rd0, rd1, input logic w0, w1, input int rst_at);
        int kd[2], dl[2], ln[2], kc[2];
        bit claim[2], rdy[2];
        int mb, c, win, exp_issue, exp_wait, exp_ready_t, lim;
        bit declined, conflict, rpath, abort_exp;
        int n11, nown, noth, nwait, nready, nabort, nconf, nbadop, t_ready;
        logic [31:0] ins, r1, r2, r3, obs_rd, exp_rd;
        logic obs_wr, exp_wr;
        logic [1:0] sv, own_mask;
        kd = '{k0, k1}; dl = '{d0, d1}; ln = '{l0, l1}; kc = '{0, 0};
        mb = sel ? MB_B : MB_A;
        // outcome model: earliest claim inside the window decides everything
        c = 1000; conflict = 0; rpath = 0; abort_exp = 0; win = 0;
        exp_wait = 0; exp_ready_t = -1;
        for (int i = 0; i < 2; i++)
            if (kd[i] != 0 && dl[i] < CLAIM && dl[i] < c) c = dl[i];
        declined = (c == 1000);
        if (!declined) begin
            for (int i = 0; i < 2; i++) begin
                claim[i] = (kd[i] != 0) && (dl[i] == c);
                rdy[i]   = claim[i] && (kd[i] == 1 || (kd[i] == 2 && ln[i] == 0));
            end
            conflict = claim[0] && claim[1];
            if (rdy[0] || rdy[1]) begin
                rpath = 1; win = rdy[0] ? 0 : 1; exp_ready_t = 2 + c;
            end else begin
                win = claim[0] ? 0 : 1;
                if (kd[win] == 2 && ln[win] <= mb) begin
                    rpath = 1; exp_wait = ln[win]; exp_ready_t = 2 + c + ln[win];
                end else begin
                    abort_exp = 1; exp_wait = mb;
                end
            end
        end
        exp_issue = declined ? CLAIM : c + 1;
        lim = declined ? CLAIM + 12 : (rpath ? exp_ready_t + 1 : 2 + c + mb + 4);
        exp_rd = win ? rd1 : rd0;
        exp_wr = win ? w1 : w0;
        own_mask = win ? 2'b10 : 2'b01;

        ins = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
        m_insn = ins; m_rs1 = r1; m_rs2 = r2; m_rs3 = r3; m_valid = 1'b1;
        n11 = 0; nown = 0; noth = 0; nwait = 0; nready = 0; nabort = 0; nconf = 0;
        nbadop = 0; t_ready = -1; obs_rd = 'x; obs_wr = 1'bx;
        for (int t = 0; t < lim + 4; t++) begin
            sv = o_sv;
            if (rst_at >= 0 && t == rst_at) chk("busy_before_reset", {63'd0, o_wait}, 64'd1);
            if (rst_at >= 0 && t == rst_at + 1) begin
                chk_zero("after_reset");
                reset = 1'b0; m_valid = 1'b0; s_wait = '0; s_ready = '0;
                @(negedge clk);
                break;
            end
            if (sv == 2'b11) n11++;
            else if (sv != 2'b00) begin
                if (!declined && sv == own_mask) nown++; else noth++;
            end
            if (sv != 2'b00 && {o_insn, o_rs1, o_rs2, o_rs3} !== {ins, r1, r2, r3}) nbadop++;
            if (o_wait) nwait++;
            if (o_ready) begin
                nready++;
                if (t_ready < 0) begin t_ready = t; obs_rd = o_rd; obs_wr = o_wr; end
            end
            if (o_abort) nabort++;
            if (o_conf) nconf++;
            for (int i = 0; i < 2; i++) begin
                s_wait[i] = 1'b0; s_ready[i] = 1'b0;
                if (sv[i]) begin
                    case (kd[i])
                        1: s_ready[i] = (kc[i] == dl[i]);
                        2: begin
                            s_wait[i]  = (kc[i] >= dl[i]) && (kc[i] < dl[i] + ln[i]);
                            s_ready[i] = (kc[i] == dl[i] + ln[i]);
                        end
                        3: s_wait[i] = (kc[i] >= dl[i]);
                        default: ;
                    endcase
                    kc[i]++;
                end
                s_rd[32*i +: 32] = s_ready[i] ? (i == 0 ? rd0 : rd1) : $urandom;
                s_wr[i] = s_ready[i] ? (i == 0 ? w0 : w1) : 1'($urandom);
            end
            if (t >= 1) begin
                m_insn = $urandom; m_rs1 = $urandom; m_rs2 = $urandom; m_rs3 = $urandom;
            end
            if ((t_ready >= 0 && t > t_ready) || t >= lim) m_valid = 1'b0;
            if (rst_at == t) reset = 1'b1;
            @(negedge clk);
        end
        m_valid = 1'b0; s_wait = '0; s_ready = '0;
        repeat (2) @(negedge clk);
        if (rst_at < 0) begin
            chk("issue_cycles", n11, exp_issue);
            chk("owner_cycles", nown, exp_wait);
            chk("stray_valid", noth, 0);
            chk("wait_cycles", nwait, exp_wait);
            chk("ready_pulses", nready, rpath ? 1 : 0);
            chk("abort_pulses", nabort, abort_exp ? 1 : 0);
            chk("conflict_pulses", nconf, conflict ? 1 : 0);
            chk("operands", nbadop, 0);
            chk("valid_idle", {62'd0, o_sv}, 64'd0);
            if (rpath) begin
                chk("ready_time", t_ready, exp_ready_t);
                chk("rd", {32'd0, obs_rd}, {32'd0, exp_rd});
                chk("wr", {63'd0, obs_wr}, {63'd0, exp_wr});
                chk("rd_hold", {32'd0, o_rd}, {32'd0, exp_rd});
            end
        end
    endtask

    initial begin
        int k[2], d[2], l[2];
        reset = 1'b1; sel = 1'b0; m_valid = 1'b0;
        m_insn = '0; m_rs1 = '0; m_rs2 = '0; m_rs3 = '0;
        s_wr = '0; s_rd = '0; s_wait = '0; s_ready = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset_a");
        sel = 1'b1;
        chk_zero("reset_b");
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run_txn(1, 0, 0, 0, 0, 0, 32'h12345678, $urandom, 1'b1, 1'b0, -1);
        run_txn(0, 0, 0, 2, 0, 10, $urandom, 32'hDEADBEEF, 1'b0, 1'b1, -1);
        run_txn(0, 0, 0, 0, 0, 0, $urandom, $urandom, 1'b1, 1'b1, -1);
        sel = 1'b1;
        run_txn(3, 0, 0, 0, 0, 0, $urandom, $urandom, 1'b1, 1'b1, -1);
        sel = 1'b0;
        run_txn(1, 0, 0, 1, 0, 0, 32'd1, 32'd2, 1'b1, 1'b1, -1);
        run_txn(2, 1, 3, 2, 1, 5, $urandom, $urandom, 1'b0, 1'b1, -1);
        run_txn(0, 0, 0, 1, 3, 0, $urandom, $urandom, 1'b0, 1'b1, -1);
        run_txn(1, 4, 0, 2, 5, 2, $urandom, $urandom, 1'b1, 1'b1, -1);
        sel = 1'b1;
        run_txn(2, 0, 8, 0, 0, 0, $urandom, $urandom, 1'b1, 1'b0, -1);
        run_txn(2, 2, 9, 0, 0, 0, $urandom, $urandom, 1'b1, 1'b0, -1);
        sel = 1'b0;
        run_txn(0, 0, 0, 3, 0, 0, $urandom, $urandom, 1'b1, 1'b1, 5);
        run_txn(0, 0, 0, 1, 1, 0, $urandom, 32'hCAFEF00D, 1'b0, 1'b1, -1);

        for (int n = 0; n < 30; n++) begin
            sel = 1'($urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                k[i] = $urandom_range(0, 3);
                d[i] = $urandom_range(0, 5);
                l[i] = $urandom_range(0, 12);
                if (!sel && k[i] == 3) k[i] = 2;
            end
            run_txn(k[0], d[0], l[0], k[1], d[1], l[1], $urandom, $urandom,
                    1'($urandom), 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
